sclk_monitor: RTL

- Receiving end of the divided-clock path. Takes the slow square wave produced by the clock divider and synchronises it into the fast clk domain.
- Emits single-cycle rise/fall enable pulses for downstream fast-domain logic, so that logic never clocks on the slow clock directly.
- Measures the half-period in clk cycles, flags frequency deviation against the expected divider setting, and flags a stalled or absent slow clock.

---
 rtl/sclk_monitor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sclk_monitor.sv
// sclk_monitor: brings the divided slow clock into the clk domain, emits
// rise/fall enable pulses and checks half-period against the divider setting.
//
// Ports:
//   clk          fast system clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   sclk_in      divided clock, asynchronous to clk
//   rise_pulse   one-cycle pulse per detected rising edge of sclk_in
//   fall_pulse   one-cycle pulse per detected falling edge of sclk_in
//   half_period  last measured edge-to-edge interval in clk cycles
//   period_valid half_period holds a genuine measurement
//   freq_err     last measurement outside EXP_HALF +/- TOL
//   stalled      no edge seen for TIMEOUT cycles
`timescale 1ns/1ps

module sclk_monitor #(
    parameter int CNT_W    = 16,
    parameter int EXP_HALF = 2201,
    parameter int TOL      = 16,
    parameter int TIMEOUT  = 8804
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             freq_err,
    output logic             stalled
);

    // The counter must reach TIMEOUT even when half_period is narrower,
    // so it is sized for whichever of the two needs more bits.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (CNT_W > TW) ? CNT_W : TW;

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] MEAS_SAT = CW'({CNT_W{1'b1}});
    localparam logic [CW:0]   TO_V     = (CW+1)'(TIMEOUT);
    localparam logic signed [CNT_W:0] EXP_V = (CNT_W+1)'(EXP_HALF);
    localparam logic [CNT_W:0] TOL_V   = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {
        INIT,
        ARM,
        LOCK,
        STALL
    } state_t;

    state_t state, state_n;

    logic s1, s2, s3;
    logic rise, fall, edge_det;

    logic [CW-1:0]    cnt;
    logic [CW:0]      cnt_inc;
    logic [CNT_W-1:0] meas;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]   abs_diff;
    logic             meas_err;
    logic             timeout;

    logic [CNT_W-1:0] hp_n;
    logic             pv_n, fe_n, st_n;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign edge_det = rise | fall;

    assign cnt_inc  = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign meas     = (cnt >= MEAS_SAT) ? {CNT_W{1'b1}}
                                        : cnt_inc[CNT_W-1:0];
    assign diff     = $signed({1'b0, meas}) - EXP_V;
    assign abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign meas_err = abs_diff > TOL_V;
    assign timeout  = cnt_inc >= TO_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= sclk_in;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= rise;
            fall_pulse <= fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt_inc[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            half_period  <= '0;
            period_valid <= 1'b0;
            freq_err     <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state        <= state_n;
            half_period  <= hp_n;
            period_valid <= pv_n;
            freq_err     <= fe_n;
            stalled      <= st_n;
        end
    end

    // An edge always takes priority over the timeout in the same cycle.
    always_comb begin
        state_n = state;
        hp_n    = half_period;
        pv_n    = period_valid;
        fe_n    = freq_err;
        st_n    = stalled;
        unique case (state)
            INIT: begin
                if (edge_det) begin
                    state_n = ARM;
                end else if (timeout) begin
                    state_n = STALL;
                    st_n    = 1'b1;
                    pv_n    = 1'b0;
                    fe_n    = 1'b0;
                end
            end
            ARM, LOCK: begin
                if (edge_det) begin
                    state_n = LOCK;
                    hp_n    = meas;
                    pv_n    = 1'b1;
                    fe_n    = meas_err;
                end else if (timeout) begin
                    state_n = STALL;
                    st_n    = 1'b1;
                    pv_n    = 1'b0;
                    fe_n    = 1'b0;
                end
            end
            STALL: begin
                if (edge_det) begin
                    state_n = ARM;
                    st_n    = 1'b0;
                end
            end
            default: state_n = INIT;
        endcase
    end

endmodule
